// File: rtl/isa_pkg.sv
// ISA constants, run-control states and the field-to-word encoder used by the instruction encoder and decoder.
// Latency: pure combinational definitions, no state.
// Backpressure: not applicable.
package isa_pkg;

   localparam logic [3:0] OP_RTYPE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JUMP  = 4'h4;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int R1_MSB    = 11;
   localparam int R1_LSB    = 8;
   localparam int R2_MSB    = 7;
   localparam int R2_LSB    = 4;
   localparam int R3_MSB    = 3;
   localparam int R3_LSB    = 0;
   localparam int IMM_MSB   = 7;
   localparam int IMM_LSB   = 0;
   localparam int JADDR_MSB = 11;
   localparam int JADDR_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } run_state_t;

   typedef struct packed {
      logic        legal;
      logic [15:0] word;
   } enc_t;

   // Pack the fields for the given opcode; fields the format does not use are ignored.
   // I-type drops reg2 because the decoder reads imm[7:4] in that slot.
   function automatic enc_t encode_instr(input logic [3:0]  op,
                                         input logic [3:0]  r1,
                                         input logic [3:0]  r2,
                                         input logic [3:0]  r3,
                                         input logic [7:0]  imm,
                                         input logic [11:0] jaddr);
      enc_t e;
      e.legal = 1'b1;
      e.word  = '0;
      e.word[OP_MSB:OP_LSB] = op;
      case (op)
         OP_RTYPE: begin
            e.word[R1_MSB:R1_LSB] = r1;
            e.word[R2_MSB:R2_LSB] = r2;
            e.word[R3_MSB:R3_LSB] = r3;
         end
         OP_LOAD, OP_STORE: begin
            e.word[R1_MSB:R1_LSB]   = r1;
            e.word[IMM_MSB:IMM_LSB] = imm;
         end
         OP_JUMP: begin
            e.word[JADDR_MSB:JADDR_LSB] = jaddr;
         end
         default: begin
            e.legal = 1'b0;
            e.word  = '0;
         end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Two-entry in-order valid/ready buffer holding encoded words on their way to instruction memory.
// Latency: a pushed entry is visible on out_dat the cycle after the push.
// Backpressure: pushes are dropped when full (producer watches count); head is held while out_ready=0.
module instr_skid_buf #(
   parameter int DW = 25
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          mark_tail,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_dat,
   output logic [1:0]    count
);

   logic [1:0][DW-1:0] mem;
   logic               wr_ptr;
   logic               rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign do_push   = push && (count != 2'd2);
   assign do_pop    = out_ready && (count != 2'd0);
   assign out_valid = (count != 2'd0);
   assign out_dat   = mem[rd_ptr];

   // Circular storage; mark_tail sets the flag bit (bit 0) of the newest entry so a
   // program can be terminated after its last word was already queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (mark_tail && (count != 2'd0)) begin
            mem[~wr_ptr][0] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/instr_word_encoder.sv
// Packs instruction field bundles into 16-bit ISA words with sequential write addresses.
// Latency: one cycle from input transfer to out_valid; one word per cycle when out_ready=1.
// Backpressure: in_ready comes only from skid occupancy (registered state), never from out_ready.
module instr_word_encoder
   import isa_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [3:0]        in_reg1,
   input  logic [3:0]        in_reg2,
   input  logic [3:0]        in_reg3,
   input  logic [7:0]        in_imm,
   input  logic [11:0]       in_jaddr,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              done,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic              wrap_sticky,
   output logic [ADDR_W:0]   word_count
);

   localparam int                SKID_W = 16 + ADDR_W + 1;
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

   run_state_t        state_q;
   run_state_t        state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              last_acc_q;
   logic              err_pulse_q;
   logic              err_sticky_q;
   logic              wrap_sticky_q;
   logic [ADDR_W:0]   word_count_q;

   enc_t              enc;
   logic              in_xfer;
   logic              out_xfer;
   logic              push;
   logic              arm;
   logic              ill_last;
   logic              pend_after;
   logic              mark_tail;
   logic [1:0]        skid_cnt;
   logic [SKID_W-1:0] skid_dout;

   assign enc      = encode_instr(in_opcode, in_reg1, in_reg2, in_reg3, in_imm, in_jaddr);
   assign in_ready = (state_q == ST_RUN) && !last_acc_q && (skid_cnt != 2'd2);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign push     = in_xfer && enc.legal;
   assign arm      = start && (state_q != ST_RUN);

   // An illegal bundle flagged last closes the program on whatever word is still queued
   // after this cycle's pop; with nothing left queued the program is finished now.
   assign ill_last   = in_xfer && !enc.legal && in_last;
   assign pend_after = (skid_cnt == 2'd2) || ((skid_cnt == 2'd1) && !out_xfer);
   assign mark_tail  = ill_last && pend_after;

   assign out_word    = skid_dout[SKID_W-1 -: 16];
   assign out_addr    = skid_dout[ADDR_W:1];
   assign out_last    = skid_dout[0];
   assign done        = (state_q == ST_DONE);
   assign err_pulse   = err_pulse_q;
   assign err_sticky  = err_sticky_q;
   assign wrap_sticky = wrap_sticky_q;
   assign word_count  = word_count_q;

   instr_skid_buf #(.DW(SKID_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_dat  ({enc.word, addr_q, in_last}),
      .mark_tail (mark_tail),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dat   (skid_dout),
      .count     (skid_cnt)
   );

   // Run-control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: start arms from IDLE/DONE, the last word leaving (or an illegal last
   // with nothing queued) finishes the program.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if ((out_xfer && out_last) || (ill_last && !pend_after)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Address counter and end-of-program latch; start reloads both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= BASE;
         last_acc_q <= 1'b0;
      end else if (arm) begin
         addr_q     <= BASE;
         last_acc_q <= 1'b0;
      end else begin
         if (push) addr_q <= addr_q + ADDR_W'(1);
         if (in_xfer && in_last) last_acc_q <= 1'b1;
      end
   end

   // Error and wrap flags; the pulse marks the cycle after an illegal bundle is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse_q   <= 1'b0;
         err_sticky_q  <= 1'b0;
         wrap_sticky_q <= 1'b0;
      end else begin
         err_pulse_q <= in_xfer && !enc.legal;
         if (arm) begin
            err_sticky_q  <= 1'b0;
            wrap_sticky_q <= 1'b0;
         end else begin
            if (in_xfer && !enc.legal) err_sticky_q <= 1'b1;
            if (push && (addr_q == '1)) wrap_sticky_q <= 1'b1;
         end
      end
   end

   // Delivered-word counter, saturating at all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count_q <= '0;
      end else if (arm) begin
         word_count_q <= '0;
      end else if (out_xfer && (word_count_q != '1)) begin
         word_count_q <= word_count_q + (ADDR_W+1)'(1);
      end
   end

endmodule
